serial_subtractor_demux: RTL

Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock. The subtraction cell is a combinational full subtractor built from a 1x8 demultiplexer. It is the borrow-chain counterpart of the demux-based full adder. A registered borrow flip-flop carries the borrow between bit slots. A start/busy/done handshake fronts the block so it can sit under a small controller or testbench driver.

---
 rtl/serial_subtractor_demux_pkg.sv | 30 +++
 rtl/fs_using_1x8demux.sv | 30 +++
 rtl/serial_subtractor_demux.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serial_subtractor_demux_pkg.sv
// Shared definitions for the bit-serial demux-based subtractor: FSM state
// encoding, default operand width and the bit-counter width helper.
package serial_subtractor_demux_pkg;

    // Controller states; values are fixed so debug dumps read consistently.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Default operand/result width.
    localparam int DEF_WIDTH = 8;

    // Width of a counter that must reach w-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        int r;
        r = $clog2(w);
        if (r < 1) begin
            r = 1;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // Bit-counter width for the default operand width.
    localparam int CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/fs_using_1x8demux.sv
// Combinational full subtractor (x - y - bin) built from a 1x8 demultiplexer.
// The constant 1 is routed to the output selected by {x,y,bin}. The diff and
// borrow outputs are the OR of the minterms where each is true.
module fs_using_1x8demux (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    logic       din_s;
    logic [2:0] sel_s;
    logic [7:0] o_s;

    assign din_s = 1'b1;
    assign sel_s = {a, b, bin};

    // 1x8 demux: only the selected output carries din, all others are 0.
    always_comb begin
        o_s        = 8'h00;
        o_s[sel_s] = din_s;
    end

    // diff is odd parity of the three inputs. bout covers the minterms where
    // the subtrahend plus borrow-in exceeds the minuend bit.
    assign diff = o_s[1] | o_s[2] | o_s[4] | o_s[7];
    assign bout = o_s[1] | o_s[2] | o_s[3] | o_s[7];

endmodule

// File: rtl/serial_subtractor_demux.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit per clock.
// A start/busy/done handshake fronts the datapath. The result registers are
// updated only when a run completes, so they hold the last result while a
// new operation is in flight.
module serial_subtractor_demux
    import serial_subtractor_demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int                 CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    // The result shifts in at the MSB. Its lowest slot is never read before
    // completion, so only WIDTH-1 bits are stored.
    logic [WIDTH-2:0]   res_sh_q, res_sh_d;
    logic               borrow_q, borrow_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;

    logic               cell_diff_s;
    logic               cell_bout_s;
    logic [WIDTH-1:0]   res_cat_s;

    // One subtraction cell evaluates the current LSB pair with the stored borrow.
    fs_using_1x8demux u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .diff (cell_diff_s),
        .bout (cell_bout_s)
    );

    assign res_cat_s = {cell_diff_s, res_sh_q};

    // Next-state and datapath update for the IDLE/RUN/DONE controller.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = {CW{1'b0}};
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = res_cat_s[WIDTH-1:1];
                borrow_d = cell_bout_s;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Final bit: publish the full result and borrow together.
                    state_d = ST_DONE;
                    diff_d  = res_cat_s;
                    bout_d  = cell_bout_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            res_sh_q <= {(WIDTH-1){1'b0}};
            borrow_q <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            bout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule
